// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register addresses, STATUS
// bit positions and the transmit/receive state encodings.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DIV  = 2'b10;

    localparam int STAT_TX_BUSY  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_FERR     = 2;
    localparam int STAT_OVR      = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // A bit period below two clocks leaves no room for a half-period sample.
    function automatic logic [7:0] clamp_div(input logic [7:0] v);
        return (v < 8'd2) ? 8'd2 : v;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, eight data bits LSB first, stop bit, each bit
// lasting div clocks; div is read live at every terminal-count compare.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for start
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting out d0..d7
//   TX_STOP  | driving the stop bit (1); busy drops when it ends
import uart_pkg::*;

module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] div,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy
);

    tx_state_t  state;
    logic [7:0] cnt;
    logic [7:0] sh;
    logic [2:0] bit_idx;
    logic       bit_end;

    assign bit_end = (cnt >= div - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= 8'd0;
            sh      <= 8'd0;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        sh    <= data;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= 8'd0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        cnt     <= 8'd0;
                        tx      <= sh[0];
                        sh      <= sh >> 1;
                        bit_idx <= 3'd0;
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt <= 8'd0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            tx      <= sh[0];
                            sh      <= sh >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        cnt   <= 8'd0;
                        busy  <= 1'b0;
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: register file, baud divisor, loopback mux and the
// receiver; the transmitter lives in uart_tx.
//
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the line
//   RX_START | half-period check that the start bit is real
//   RX_DATA  | sampling d0..d7 at bit centres
//   RX_STOP  | sampling the stop bit; store byte or flag framing error
import uart_pkg::*;

module uart_mmio #(
    parameter int DEFAULT_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       rx,
    output logic       tx,
    output logic       tx_busy,
    output logic       rx_valid
);

    logic [7:0] div_r;
    logic [7:0] rx_data_r;
    logic       ovr;
    logic       ferr;
    logic       tx_start;

    assign tx_start = we && (addr == ADDR_DATA) && !tx_busy;

    uart_tx u_tx (
        .clk   (clk),
        .rst   (rst),
        .div   (div_r),
        .data  (wdata),
        .start (tx_start),
        .tx    (tx),
        .busy  (tx_busy)
    );

    logic rx_s1, rx_s2, line, line_q;

    // Loopback taps the registered tx directly; it is already in this domain.
    assign line = en ? tx : rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            rx_s1  <= rx;
            rx_s2  <= rx_s1;
            line_q <= line;
        end
    end

    rx_state_t  rx_state;
    logic [7:0] rx_cnt;
    logic [7:0] rx_sh;
    logic [2:0] rx_idx;
    logic       rx_store;
    logic       rx_ferr;
    logic [7:0] half;

    assign half = {1'b0, div_r[7:1]};

    // A line held low after a framing error never shows line_q=1,line=0, so
    // IDLE waits for it to return high before accepting a new start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 8'd0;
            rx_sh    <= 8'd0;
            rx_idx   <= 3'd0;
            rx_store <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_store <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (line_q && !line) begin
                        rx_cnt   <= 8'd0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt >= half - 8'd1) begin
                        rx_cnt <= 8'd0;
                        rx_idx <= 3'd0;
                        rx_state <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 8'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt >= div_r - 8'd1) begin
                        rx_cnt <= 8'd0;
                        rx_sh  <= {line, rx_sh[7:1]};
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 8'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt >= div_r - 8'd1) begin
                        rx_cnt   <= 8'd0;
                        rx_store <= line;
                        rx_ferr  <= !line;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 8'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Read side effects come first so a same-cycle store or error wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r     <= 8'(DEFAULT_DIV);
            rx_data_r <= 8'd0;
            rdata     <= 8'd0;
            rx_valid  <= 1'b0;
            ovr       <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            if (we && addr == ADDR_DIV) div_r <= clamp_div(wdata);
            if (re) begin
                case (addr)
                    ADDR_DATA: begin
                        rdata    <= rx_data_r;
                        rx_valid <= 1'b0;
                    end
                    ADDR_STAT: begin
                        rdata <= {4'b0, ovr, ferr, rx_valid, tx_busy};
                        ovr   <= 1'b0;
                        ferr  <= 1'b0;
                    end
                    ADDR_DIV: rdata <= div_r;
                    default:  rdata <= 8'd0;
                endcase
            end
            if (rx_store) begin
                rx_data_r <= rx_sh;
                rx_valid  <= 1'b1;
                if (rx_valid) ovr <= 1'b1;
            end
            if (rx_ferr) ferr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized self-checking bench for uart_mmio; expected frames and register
// contents come from a simple model of the 8N1 format and register map.
module tb_uart_mmio;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] addr;
    logic       we;
    logic       re;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rx;
    logic       tx;
    logic       tx_busy;
    logic       rx_valid;

    int n_checks = 0;
    int n_pass   = 0;

    uart_mmio #(.DEFAULT_DIV(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .rdata    (rdata),
        .rx       (rx),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        d = rdata;
    endtask

    // Frame bit k of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int div);
        for (int k = 0; k < 10; k++) begin
            rx = (k == 9) ? stop_val : frame_bit(b, k);
            repeat (div) tick();
        end
        rx = 1'b1;
    endtask

    task automatic wait_rx_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!rx_valid && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic wait_tx_idle(input int bound);
        int n;
        n = 0;
        while (tx_busy && n < bound) begin
            tick();
            n++;
        end
        chk("tx_idle_timeout", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b, b2;
        int         div;
        int         busy_cnt, wave_err, low_run;
        logic       stat_mid;

        rst = 1'b1; en = 1'b0; addr = 2'b00; we = 1'b0; re = 1'b0;
        wdata = 8'h00; rx = 1'b1;
        repeat (2) tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rxv", {31'd0, rx_valid}, 32'd0);
        bus_read(2'b10, d); chk("rst_div", {24'd0, d}, 32'd16);
        bus_read(2'b01, d); chk("rst_stat", {24'd0, d}, 32'd0);

        bus_write(2'b10, 8'd130);
        bus_read(2'b10, d); chk("div_130", {24'd0, d}, 32'd130);
        tick();
        chk("rdata_hold", {24'd0, rdata}, 32'd130);
        bus_write(2'b10, 8'd0);
        bus_read(2'b10, d); chk("div_0_as_2", {24'd0, d}, 32'd2);
        bus_write(2'b10, 8'd1);
        bus_read(2'b10, d); chk("div_1_as_2", {24'd0, d}, 32'd2);
        bus_write(2'b01, 8'hFF);
        bus_read(2'b01, d); chk("stat_wr_ignored", {24'd0, d}, 32'd0);

        // 0xF0 frame at 130 clocks/bit, with an ignored 0x55 write and a
        // STATUS read issued mid-frame.
        bus_write(2'b10, 8'd130);
        b = 8'hF0;
        bus_write(2'b00, b);
        busy_cnt = 0; wave_err = 0; low_run = 0; stat_mid = 1'b0;
        for (int k = 0; k < 1400; k++) begin
            if (tx_busy) busy_cnt++;
            if (tx !== ((k < 1300) ? frame_bit(b, k / 130) : 1'b1)) wave_err++;
            if (tx == 1'b0 && low_run == k) low_run++;
            if (k == 601) stat_mid = rdata[0];
            we = (k == 300); re = (k == 600);
            addr = (k == 600) ? 2'b01 : 2'b00;
            wdata = 8'h55;
            tick();
        end
        we = 1'b0; re = 1'b0;
        chk("tx_wave_f0", wave_err, 0);
        chk("tx_low_run", low_run, 650);
        chk("tx_busy_len", busy_cnt, 1300);
        chk("stat_busy_mid", {31'd0, stat_mid}, 32'd1);

        addr = 2'b10; wdata = 8'd50; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        chk("wr_rd_same_cycle", {24'd0, rdata}, 32'd130);
        bus_read(2'b10, d); chk("div_after_wr", {24'd0, d}, 32'd50);
        bus_write(2'b11, 8'hAB);
        bus_read(2'b11, d); chk("reserved_rd", {24'd0, d}, 32'd0);

        en = 1'b1;
        bus_write(2'b10, 8'd16);
        bus_write(2'b00, 8'hA5);
        wait_rx_valid("lb_a5_rxv", 160);
        bus_read(2'b00, d); chk("lb_a5_data", {24'd0, d}, 32'hA5);
        chk("lb_a5_rxv_clr", {31'd0, rx_valid}, 32'd0);
        wait_tx_idle(100);

        for (int i = 0; i < 4; i++) begin
            div = $urandom_range(4, 24);
            b   = 8'($urandom);
            bus_write(2'b10, 8'(div));
            bus_write(2'b00, b);
            wait_rx_valid("lb_rnd_rxv", 10 * div + 4);
            bus_read(2'b00, d); chk("lb_rnd_data", {24'd0, d}, {24'd0, b});
            wait_tx_idle(3 * div);
        end
        en = 1'b0;
        bus_read(2'b01, d); chk("lb_stat_clean", {24'd0, d}, 32'd0);

        bus_write(2'b10, 8'd16);
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (40) tick();
        bus_read(2'b01, d); chk("glitch_ignored", {24'd0, d}, 32'd0);

        send_frame(8'h3C, 1'b0, 16);
        rx = 1'b0;
        repeat (32) tick();
        rx = 1'b1;
        repeat (8) tick();
        bus_read(2'b01, d); chk("ferr_stat", {24'd0, d}, 32'h04);
        bus_read(2'b01, d); chk("ferr_cleared", {24'd0, d}, 32'h00);

        b  = 8'($urandom);
        b2 = 8'($urandom);
        send_frame(b, 1'b1, 16);
        send_frame(b2, 1'b1, 16);
        repeat (8) tick();
        bus_read(2'b01, d); chk("ovr_stat", {24'd0, d}, 32'h0A);
        bus_read(2'b01, d); chk("ovr_cleared", {24'd0, d}, 32'h02);
        bus_read(2'b00, d); chk("ovr_data", {24'd0, d}, {24'd0, b2});
        bus_read(2'b01, d); chk("ovr_all_clear", {24'd0, d}, 32'h00);

        for (int i = 0; i < 3; i++) begin
            div = $urandom_range(6, 20);
            b   = 8'($urandom);
            bus_write(2'b10, 8'(div));
            send_frame(b, 1'b1, div);
            repeat (6) tick();
            chk("ext_rnd_rxv", {31'd0, rx_valid}, 32'd1);
            bus_read(2'b00, d); chk("ext_rnd_data", {24'd0, d}, {24'd0, b});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
